// File: rtl/d_mem_ctrl.sv
// d_mem_ctrl: word-organised data RAM serving byte/half/word loads and stores over a
// valid/ready request and one-cycle response strobe, with fixed latency. Optional: DMEM_ALIGN_CHECK_EN.
module d_mem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       mem [DEPTH];

    logic              accept;
    logic              commit;
    logic [ADDR_W-1:0] widx_full;
    logic              range_err;
    logic              acc_err;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        lane;
    logic [3:0]        be;
    logic [31:0]       wshift;
    logic [31:0]       rword;
    logic [7:0]        rbyte;
    logic [15:0]       rhalf;
    logic [31:0]       load_data;

    assign req_ready = (state == IDLE);
    assign busy      = ~req_ready;
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid & req_ready;
    // WAIT is entered for every latency; the WAIT->RESP edge is the commit edge,
    // so the response lands exactly LATENCY edges after accept.
    assign commit    = (state == WAIT) && (cnt == '0);

    always_comb begin
        widx_full = {2'b00, addr_q[ADDR_W-1:2]};
        range_err = (widx_full >= ADDR_W'(DEPTH));
        idx       = addr_q[IDX_W+1:2];
`ifdef DMEM_ALIGN_CHECK_EN
        acc_err   = range_err || (size_q == 2'b11) ||
                    ((size_q == 2'b01) && addr_q[0]) ||
                    ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
`else
        acc_err   = range_err || (size_q == 2'b11);
`endif
        case (size_q)
            2'b00:   begin lane = addr_q[1:0];         be = 4'b0001 << addr_q[1:0]; end
            2'b01:   begin lane = {addr_q[1], 1'b0};   be = addr_q[1] ? 4'b1100 : 4'b0011; end
            2'b10:   begin lane = 2'b00;               be = 4'b1111; end
            default: begin lane = 2'b00;               be = 4'b0000; end
        endcase
        wshift = wdata_q << {lane, 3'b000};
        rword  = mem[idx];
        rbyte  = rword[{lane, 3'b000} +: 8];
        rhalf  = rword[{lane[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_data = uns_q ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
            2'b01:   load_data = uns_q ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
            default: load_data = rword;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset && commit && we_q && !acc_err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wshift[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state <= WAIT;
                        cnt   <= CNT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        rsp_err   <= acc_err;
                        rsp_rdata <= (acc_err || we_q) ? '0 : load_data;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_d_mem_ctrl.sv
// Directed self-checking bench for d_mem_ctrl (LATENCY=3, DEPTH=256); follows DMEM_ALIGN_CHECK_EN.
module tb_d_mem_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    d_mem_ctrl #(.ADDR_W(32), .DEPTH(256), .LATENCY(3)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clock = ~clock;

    // One transaction; returns response data, latency in edges, cycles seen with
    // req_ready low before the response, and rsp_valid/req_ready one edge after it.
    task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int rlow, output logic post_valid, output logic post_ready);
        @(negedge clock);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 0; rlow = 0;
        while (!rsp_valid && lat < 20) begin
            if (!req_ready) rlow++;
            @(posedge clock); #1;
            lat++;
        end
        rd = rsp_rdata; er = rsp_err;
        @(posedge clock); #1;
        post_valid = rsp_valid; post_ready = req_ready;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1; req_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(negedge clock); reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL idle_rdata got=%h exp=0", rsp_rdata); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL idle_err got=%b exp=0", rsp_err); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er, pv, pr; int lat, rl;
        xact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, rl, pv, pr);
        total++; if (lat !== 3) begin bad++; $display("FAIL sw_latency got=%0d exp=3", lat); end
        total++; if (er !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL sw_rsp got=%b/%h exp=0/0", er, rd); end
        xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, rl, pv, pr);
        total++; if (lat !== 3) begin bad++; $display("FAIL lw_latency got=%0d exp=3", lat); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL lw_err got=%b exp=0", er); end
        total++; if (rl !== 3) begin bad++; $display("FAIL lw_ready_low got=%0d exp=3", rl); end
        total++; if (pv !== 1'b0) begin bad++; $display("FAIL lw_strobe_width got=%b exp=0", pv); end
        total++; if (pr !== 1'b1) begin bad++; $display("FAIL lw_ready_after got=%b exp=1", pr); end
    endtask

    task automatic test_subword();
        logic [31:0] rd; logic er, pv, pr; int lat, rl;
        xact(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000080, rd, er, lat, rl, pv, pr);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL sb_err got=%b exp=0", er); end
        xact(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, rd, er, lat, rl, pv, pr);
        total++; if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL lb got=%h exp=ffffff80", rd); end
        xact(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, rd, er, lat, rl, pv, pr);
        total++; if (rd !== 32'h00000080) begin bad++; $display("FAIL lbu got=%h exp=00000080", rd); end
        xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, rl, pv, pr);
        total++; if (rd !== 32'hDEAD80EF) begin bad++; $display("FAIL lw_after_sb got=%h exp=dead80ef", rd); end
        xact(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, er, lat, rl, pv, pr);
        total++; if (rd !== 32'hFFFFFFEF) begin bad++; $display("FAIL lb_lane0 got=%h exp=ffffffef", rd); end
        xact(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, rd, er, lat, rl, pv, pr);
        total++; if (rd !== 32'hFFFFDEAD) begin bad++; $display("FAIL lh got=%h exp=ffffdead", rd); end
        xact(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, er, lat, rl, pv, pr);
        total++; if (rd !== 32'h0000DEAD) begin bad++; $display("FAIL lhu got=%h exp=0000dead", rd); end
        xact(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, rd, er, lat, rl, pv, pr);
        total++; if (rd !== 32'hDEAD80EF) begin bad++; $display("FAIL lw_unsigned got=%h exp=dead80ef", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er, pv, pr; int lat, rl;
        xact(1'b1, 2'b10, 1'b0, 32'h0, 32'h11223344, rd, er, lat, rl, pv, pr);
        xact(1'b1, 2'b10, 1'b0, 32'h400, 32'hFFFFFFFF, rd, er, lat, rl, pv, pr);
        total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL sw_range got=%b/%h exp=1/0", er, rd); end
        xact(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, rd, er, lat, rl, pv, pr);
        total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL lw_range got=%b/%h exp=1/0", er, rd); end
        xact(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, er, lat, rl, pv, pr);
        total++; if (rd !== 32'h11223344) begin bad++; $display("FAIL no_wrap got=%h exp=11223344", rd); end
        xact(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rd, er, lat, rl, pv, pr);
        total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL ld_size11 got=%b/%h exp=1/0", er, rd); end
        xact(1'b1, 2'b11, 1'b0, 32'h10, 32'h0, rd, er, lat, rl, pv, pr);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL st_size11 got=%b exp=1", er); end
        xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, rl, pv, pr);
        total++; if (rd !== 32'hDEAD80EF) begin bad++; $display("FAIL st_size11_nowrite got=%h exp=dead80ef", rd); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; logic er, pv, pr; int lat, rl;
        logic        exp_err;
        logic [31:0] exp_lh, exp_lw, exp_w0;
`ifdef DMEM_ALIGN_CHECK_EN
        exp_err = 1'b1; exp_lh = 32'h0; exp_lw = 32'h0; exp_w0 = 32'h11223344;
`else
        exp_err = 1'b0; exp_lh = 32'hFFFFDEAD; exp_lw = 32'hDEAD80EF; exp_w0 = 32'h55667788;
`endif
        xact(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, rd, er, lat, rl, pv, pr);
        total++; if (er !== exp_err || rd !== exp_lh) begin bad++; $display("FAIL lh_0x13 got=%b/%h exp=%b/%h", er, rd, exp_err, exp_lh); end
        xact(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, rd, er, lat, rl, pv, pr);
        total++; if (er !== exp_err || rd !== exp_lw) begin bad++; $display("FAIL lw_0x11 got=%b/%h exp=%b/%h", er, rd, exp_err, exp_lw); end
        xact(1'b1, 2'b10, 1'b0, 32'h3, 32'h55667788, rd, er, lat, rl, pv, pr);
        total++; if (er !== exp_err) begin bad++; $display("FAIL sw_0x03_err got=%b exp=%b", er, exp_err); end
        xact(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, er, lat, rl, pv, pr);
        total++; if (rd !== exp_w0) begin bad++; $display("FAIL sw_0x03_effect got=%h exp=%h", rd, exp_w0); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd; logic er, pv, pr; int lat, rl, seen;
        xact(1'b1, 2'b10, 1'b0, 32'h20, 32'h01020304, rd, er, lat, rl, pv, pr);
        @(negedge clock);
        req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h20;
        req_wdata = 32'hCAFEBABE; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midop_busy got=%b exp=1", busy); end
        @(posedge clock);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL midop_idle got=%b/%b exp=1/0", req_ready, rsp_valid); end
        @(negedge clock); reset = 1'b0;
        seen = 0;
        repeat (6) begin @(posedge clock); #1; if (rsp_valid) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL midop_no_rsp got=%0d exp=0", seen); end
        xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat, rl, pv, pr);
        total++; if (rd !== 32'h01020304) begin bad++; $display("FAIL midop_no_write got=%h exp=01020304", rd); end
    endtask

    task automatic test_reset_vs_accept();
        int seen;
        @(negedge clock);
        req_we = 1'b0; req_size = 2'b10; req_addr = 32'h10; req_valid = 1'b1; reset = 1'b1;
        @(posedge clock); #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_wins_ready got=%b exp=1", req_ready); end
        @(negedge clock); req_valid = 1'b0; reset = 1'b0;
        seen = 0;
        repeat (6) begin @(posedge clock); #1; if (rsp_valid) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL rst_wins_no_rsp got=%0d exp=0", seen); end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        test_reset();
        test_word();
        test_subword();
        test_errors();
        test_misalign();
        test_reset_midop();
        test_reset_vs_accept();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
